dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the core load/store unit (m0) and a DMA/debug port (m1). It accepts one request per cycle under round-robin priority with a bounded m1 lock for bursts. Each accepted request passes through a one-entry command register that drives the memory, and read data is returned to the originating requester one cycle later. The block sits directly in front of the data memory, whose read path is combinational and whose byte-masked write is on the clock edge.

---
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core load/store
// unit (m0) and a DMA/debug port (m1).
// - Grants are combinational and use round-robin priority, with a bounded m1
//   lock for bursts.
// - Each accepted request is held in a one-entry command register that drives
//   the memory for one cycle.
// - Read data returns to the originating port one edge later.
module dmem_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  // m0: core load/store unit
  input  logic              i_m0_req,
  input  logic              i_m0_wr,
  input  logic [AW-1:0]     i_m0_addr,
  input  logic [XLEN-1:0]   i_m0_wdata,
  input  logic [XLEN/8-1:0] i_m0_bsel,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [XLEN-1:0]   o_m0_rdata,
  // m1: DMA / debug port
  input  logic              i_m1_req,
  input  logic              i_m1_wr,
  input  logic [AW-1:0]     i_m1_addr,
  input  logic [XLEN-1:0]   i_m1_wdata,
  input  logic [XLEN/8-1:0] i_m1_bsel,
  input  logic              i_m1_lock,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [XLEN-1:0]   o_m1_rdata,
  // data memory: combinational read, byte-masked write on the clock edge
  output logic              o_mem_wr_en,
  output logic [AW-1:0]     o_mem_addr,
  output logic [XLEN-1:0]   o_mem_data,
  output logic [XLEN/8-1:0] o_mem_byte_sel,
  input  logic [XLEN-1:0]   i_mem_data
);

  localparam int BW  = XLEN / 8;
  localparam int LCW = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    SEL_M0 = 1'b0,
    SEL_M1 = 1'b1
  } sel_e;

  // Arbitration state
  sel_e            rr_last_q, rr_last_d;    // requester granted most recently
  logic            lock_q, lock_d;          // m1 currently owns a locked burst
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;  // locked m1 grants while m0 waited

  // One-entry command register
  logic            cmd_valid_q, cmd_valid_d;
  sel_e            cmd_id_q, cmd_id_d;
  logic            cmd_wr_q, cmd_wr_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [XLEN-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [BW-1:0]   cmd_bsel_q, cmd_bsel_d;

  // Read response registers
  logic            m0_rvalid_q, m0_rvalid_d;
  logic            m1_rvalid_q, m1_rvalid_d;
  logic [XLEN-1:0] m0_rdata_q, m0_rdata_d;
  logic [XLEN-1:0] m1_rdata_q, m1_rdata_d;

  logic m0_gnt;
  logic m1_gnt;
  logic lock_hold;
  logic lock_expired;

  // Grant selection: lock overrides round-robin until m0 has waited MAX_LOCK grants
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    lock_hold    = lock_q & i_m1_lock;
    lock_expired = lock_hold && (lock_cnt_q == LCW'(MAX_LOCK));
    // Grants are suppressed while reset is asserted, so every output reads 0.
    if (i_rstn) begin
      if (i_m0_req && i_m1_req) begin
        if (lock_expired)              m0_gnt = 1'b1;
        else if (lock_hold)            m1_gnt = 1'b1;
        else if (rr_last_q == SEL_M1)  m0_gnt = 1'b1;
        else                           m1_gnt = 1'b1;
      end else begin
        m0_gnt = i_m0_req;
        m1_gnt = i_m1_req;
      end
    end
  end

  // Next state for round-robin pointer and lock bookkeeping
  always_comb begin
    rr_last_d  = rr_last_q;
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
    if (m0_gnt)      rr_last_d = SEL_M0;
    else if (m1_gnt) rr_last_d = SEL_M1;

    if (!i_m1_lock) begin
      lock_d     = 1'b0;
      lock_cnt_d = '0;
    end else if (m1_gnt) begin
      lock_d = 1'b1;
      // Only grants that actually made m0 wait count against the bound.
      if (i_m0_req) lock_cnt_d = lock_cnt_q + LCW'(1);
    end else if (m0_gnt && lock_expired) begin
      lock_cnt_d = '0;
    end
  end

  // Capture the granted request into the command register
  always_comb begin
    cmd_valid_d = m0_gnt | m1_gnt;
    cmd_id_d    = cmd_id_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_bsel_d  = cmd_bsel_q;
    if (m1_gnt) begin
      cmd_id_d    = SEL_M1;
      cmd_wr_d    = i_m1_wr;
      cmd_addr_d  = i_m1_addr;
      cmd_wdata_d = i_m1_wdata;
      cmd_bsel_d  = i_m1_bsel;
    end else if (m0_gnt) begin
      cmd_id_d    = SEL_M0;
      cmd_wr_d    = i_m0_wr;
      cmd_addr_d  = i_m0_addr;
      cmd_wdata_d = i_m0_wdata;
      cmd_bsel_d  = i_m0_bsel;
    end
  end

  // Route memory read data of an issued read back to its requester
  always_comb begin
    m0_rvalid_d = cmd_valid_q & ~cmd_wr_q & (cmd_id_q == SEL_M0);
    m1_rvalid_d = cmd_valid_q & ~cmd_wr_q & (cmd_id_q == SEL_M1);
    m0_rdata_d  = m0_rvalid_d ? i_mem_data : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? i_mem_data : m1_rdata_q;
  end

  // State registers; reset clears any in-flight command and pending response
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rr_last_q   <= SEL_M1;
      lock_q      <= 1'b0;
      lock_cnt_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= SEL_M0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_bsel_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      // NOTE: the payload and rdata registers are reset too, not only the
      // valid bits, because they drive module outputs that must read 0 in reset.
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples its pre-edge
      // inputs regardless of statement order.
      rr_last_q   <= rr_last_d;
      lock_q      <= lock_d;
      lock_cnt_q  <= lock_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_bsel_q  <= cmd_bsel_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign o_m0_gnt       = m0_gnt;
  assign o_m1_gnt       = m1_gnt;
  assign o_m0_rvalid    = m0_rvalid_q;
  assign o_m1_rvalid    = m1_rvalid_q;
  assign o_m0_rdata     = m0_rdata_q;
  assign o_m1_rdata     = m1_rdata_q;
  // Write enable comes straight from the async-reset flops, so it drops at reset.
  assign o_mem_wr_en    = cmd_valid_q & cmd_wr_q;
  assign o_mem_addr     = cmd_addr_q;
  assign o_mem_data     = cmd_wdata_q;
  assign o_mem_byte_sel = cmd_bsel_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: table-driven arbitration/read-return vectors plus
// directed sequences for partial writes, zero-mask writes and mid-cycle reset.
module tb_dmem_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 8;

  localparam logic [31:0] DA = 32'hAAAA0001;  // mem[0x10]
  localparam logic [31:0] DB = 32'hBBBB0002;  // mem[0x20]

  logic            clk;
  logic            rst_n;
  logic            m0_req, m0_wr, m1_req, m1_wr, m1_lock;
  logic [AW-1:0]   m0_addr, m1_addr;
  logic [XLEN-1:0] m0_wdata, m1_wdata;
  logic [3:0]      m0_bsel, m1_bsel;
  logic            o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid;
  logic [XLEN-1:0] o_m0_rdata, o_m1_rdata;
  logic            o_mem_wr_en;
  logic [AW-1:0]   o_mem_addr;
  logic [XLEN-1:0] o_mem_data;
  logic [3:0]      o_mem_byte_sel;
  logic [XLEN-1:0] i_mem_data;

  // Bench-side preload port into the memory model
  logic            tb_we;
  logic [AW-1:0]   tb_waddr;
  logic [XLEN-1:0] tb_wdata;
  logic [XLEN-1:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        m0_req;
    logic        m1_req;
    logic        m1_lock;
    logic        exp_g0;
    logic        exp_g1;
    logic        exp_v0;
    logic        exp_v1;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
  } vec_t;

  vec_t vecs[$];

  dmem_arbiter #(.XLEN(XLEN), .AW(AW), .MAX_LOCK(4)) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_m0_req(m0_req), .i_m0_wr(m0_wr), .i_m0_addr(m0_addr),
    .i_m0_wdata(m0_wdata), .i_m0_bsel(m0_bsel),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(m1_req), .i_m1_wr(m1_wr), .i_m1_addr(m1_addr),
    .i_m1_wdata(m1_wdata), .i_m1_bsel(m1_bsel), .i_m1_lock(m1_lock),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_mem_wr_en(o_mem_wr_en), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_byte_sel(o_mem_byte_sel), .i_mem_data(i_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, byte-masked write on the rising edge
  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end else if (o_mem_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_byte_sel[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_data[8*b +: 8];
    end
  end
  assign i_mem_data = mem[o_mem_addr];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r0, input logic r1, input logic lk,
                         input logic g0, input logic g1, input logic v0, input logic v1,
                         input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.m0_req = r0; v.m1_req = r1; v.m1_lock = lk;
    v.exp_g0 = g0; v.exp_g1 = g1; v.exp_v0 = v0; v.exp_v1 = v1;
    v.exp_d0 = d0; v.exp_d1 = d1;
    vecs.push_back(v);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; drives, samples at the falling edge
  task automatic run_vec(input vec_t v, input int idx);
    m0_req = v.m0_req; m1_req = v.m1_req; m1_lock = v.m1_lock;
    @(negedge clk);
    check_bit($sformatf("vec%0d m0_gnt", idx), o_m0_gnt, v.exp_g0);
    check_bit($sformatf("vec%0d m1_gnt", idx), o_m1_gnt, v.exp_g1);
    check_bit($sformatf("vec%0d m0_rvalid", idx), o_m0_rvalid, v.exp_v0);
    check_bit($sformatf("vec%0d m1_rvalid", idx), o_m1_rvalid, v.exp_v1);
    check_word($sformatf("vec%0d m0_rdata", idx), o_m0_rdata, v.exp_d0);
    check_word($sformatf("vec%0d m1_rdata", idx), o_m1_rdata, v.exp_d1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Round-robin reads, then a locked m1 burst, then lock released.
    // Read data shows up 2 edges after the grant on the granting port only.
    //       r0 r1 lk   g0 g1 v0 v1  d0  d1
    add_vec(1, 1, 0,   1, 0, 0, 0,  0,  0);   // 0: first tie -> m0
    add_vec(1, 1, 0,   0, 1, 0, 0,  0,  0);   // 1
    add_vec(1, 1, 0,   1, 0, 1, 0,  DA, 0);   // 2
    add_vec(1, 1, 0,   0, 1, 0, 1,  DA, DB);  // 3
    add_vec(1, 1, 0,   1, 0, 1, 0,  DA, DB);  // 4
    add_vec(1, 1, 0,   0, 1, 0, 1,  DA, DB);  // 5
    add_vec(0, 0, 0,   0, 0, 1, 0,  DA, DB);  // 6: drain
    add_vec(0, 0, 0,   0, 0, 0, 1,  DA, DB);  // 7
    add_vec(1, 0, 0,   1, 0, 0, 0,  DA, DB);  // 8: m0 solo, last = m0
    add_vec(1, 1, 1,   0, 1, 0, 0,  DA, DB);  // 9: locked m1 grant 1
    add_vec(1, 1, 1,   0, 1, 1, 0,  DA, DB);  // 10: grant 2
    add_vec(1, 1, 1,   0, 1, 0, 1,  DA, DB);  // 11: grant 3
    add_vec(1, 1, 1,   0, 1, 0, 1,  DA, DB);  // 12: grant 4
    add_vec(1, 1, 1,   1, 0, 0, 1,  DA, DB);  // 13: bound reached -> m0
    add_vec(1, 1, 1,   0, 1, 0, 1,  DA, DB);  // 14: m1 resumes
    add_vec(1, 1, 1,   0, 1, 1, 0,  DA, DB);  // 15
    add_vec(1, 1, 1,   0, 1, 0, 1,  DA, DB);  // 16
    add_vec(1, 1, 1,   0, 1, 0, 1,  DA, DB);  // 17
    add_vec(1, 1, 1,   1, 0, 0, 1,  DA, DB);  // 18: bound again -> m0
    add_vec(1, 1, 0,   0, 1, 0, 1,  DA, DB);  // 19: lock dropped, alternate
    add_vec(1, 1, 0,   1, 0, 1, 0,  DA, DB);  // 20
    add_vec(1, 1, 0,   0, 1, 0, 1,  DA, DB);  // 21
    add_vec(1, 1, 0,   1, 0, 1, 0,  DA, DB);  // 22
    add_vec(0, 0, 0,   0, 0, 0, 1,  DA, DB);  // 23
    add_vec(0, 0, 0,   0, 0, 1, 0,  DA, DB);  // 24

    // Reset held with both requesters active
    rst_n = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h10; m0_wdata = '0; m0_bsel = 4'hF;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h20; m1_wdata = '0; m1_bsel = 4'hF;
    m1_lock = 1'b0;
    @(posedge clk); #1;
    preload(8'h00, 32'h0);
    preload(8'h10, DA);
    preload(8'h20, DB);
    preload(8'h05, 32'hFFFFFFFF);
    preload(8'h03, 32'hCAFEF00D);
    preload(8'h07, 32'h77777777);
    @(negedge clk);
    check_bit("rst m0_gnt", o_m0_gnt, 1'b0);
    check_bit("rst m1_gnt", o_m1_gnt, 1'b0);
    check_bit("rst m0_rvalid", o_m0_rvalid, 1'b0);
    check_bit("rst m1_rvalid", o_m1_rvalid, 1'b0);
    check_word("rst m0_rdata", o_m0_rdata, 32'h0);
    check_word("rst m1_rdata", o_m1_rdata, 32'h0);
    check_bit("rst mem_wr_en", o_mem_wr_en, 1'b0);
    check_word("rst mem_addr", 32'(o_mem_addr), 32'h0);
    check_word("rst mem_data", o_mem_data, 32'h0);
    check_word("rst mem_byte_sel", 32'(o_mem_byte_sel), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Partial write by m0 followed by an m1 read of the same word
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h05; m0_wdata = 32'h12345678; m0_bsel = 4'b0011;
    m1_req = 1'b0;
    @(negedge clk);
    check_bit("wr m0_gnt", o_m0_gnt, 1'b1);
    check_bit("wr m1_gnt idle", o_m1_gnt, 1'b0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h05;
    @(negedge clk);
    check_bit("wr m1_gnt", o_m1_gnt, 1'b1);
    check_bit("wr mem_wr_en", o_mem_wr_en, 1'b1);
    check_word("wr mem_addr", 32'(o_mem_addr), 32'h5);
    check_word("wr mem_data", o_mem_data, 32'h12345678);
    check_word("wr mem_byte_sel", 32'(o_mem_byte_sel), 32'h3);
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    check_bit("wr read issue wr_en", o_mem_wr_en, 1'b0);
    check_word("wr mem[5]", mem[5], 32'hFFFF5678);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("wr m1_rvalid", o_m1_rvalid, 1'b1);
    check_word("wr m1_rdata", o_m1_rdata, 32'hFFFF5678);
    check_bit("wr m0_rvalid", o_m0_rvalid, 1'b0);
    check_word("wr m0_rdata held", o_m0_rdata, DA);
    @(posedge clk); #1;

    // m1 write with an all-zero byte mask
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h03; m1_wdata = 32'h11111111; m1_bsel = 4'b0000;
    @(negedge clk);
    check_bit("bz m1_gnt", o_m1_gnt, 1'b1);
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    check_bit("bz mem_wr_en", o_mem_wr_en, 1'b1);
    check_word("bz mem_addr", 32'(o_mem_addr), 32'h3);
    check_word("bz mem_byte_sel", 32'(o_mem_byte_sel), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("bz wr_en low", o_mem_wr_en, 1'b0);
    check_bit("bz m0_rvalid", o_m0_rvalid, 1'b0);
    check_bit("bz m1_rvalid", o_m1_rvalid, 1'b0);
    check_word("bz mem[3]", mem[3], 32'hCAFEF00D);
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("bz m0_rvalid late", o_m0_rvalid, 1'b0);
    check_bit("bz m1_rvalid late", o_m1_rvalid, 1'b0);
    @(posedge clk); #1;

    // Reset asserted mid-cycle during an m0 write with an m1 response pending
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h20; m1_bsel = 4'hF;
    @(negedge clk);
    check_bit("rm m1_gnt", o_m1_gnt, 1'b1);
    @(posedge clk); #1;
    m1_req = 1'b0;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h07; m0_wdata = 32'h0BADBEEF; m0_bsel = 4'hF;
    @(negedge clk);
    check_bit("rm m0_gnt", o_m0_gnt, 1'b1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    check_bit("rm wr_en before", o_mem_wr_en, 1'b1);
    check_word("rm mem_addr before", 32'(o_mem_addr), 32'h7);
    check_bit("rm m1_rvalid before", o_m1_rvalid, 1'b1);
    check_word("rm m1_rdata before", o_m1_rdata, DB);
    #1 rst_n = 1'b0;
    #1;
    check_bit("rm wr_en after", o_mem_wr_en, 1'b0);
    check_bit("rm m1_rvalid after", o_m1_rvalid, 1'b0);
    check_word("rm m1_rdata after", o_m1_rdata, 32'h0);
    check_word("rm mem_addr after", 32'(o_mem_addr), 32'h0);
    @(posedge clk); #1;
    check_word("rm mem[7]", mem[7], 32'h77777777);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
